// File: rtl/riscv_pipe_pkg.sv
// Shared types and constants for the fetch/decode pipeline.
package riscv_pipe_pkg;

    // Occupancy of the IF/ID register pair: nothing held, main only, main plus skid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } skid_state_t;

    // addi x0,x0,0 -- inserted into the main register when a redirect flushes the stage.
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

endpackage

// File: rtl/dff_async_reset.sv
// Enabled register with asynchronous active-low clear.
module dff_async_reset #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Clear immediately on reset, otherwise load only when enabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (wr_en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with a one-entry skid buffer.
// in_ready depends only on registered state, so decode back-pressure never
// reaches fetch combinationally; the skid entry absorbs the word that was
// already accepted in the cycle decode stalled.
module if_id_skid_reg
    import riscv_pipe_pkg::*;
#(
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PC_WIDTH-1:0]    in_pc,
    input  logic [INSTR_WIDTH-1:0] in_instr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PC_WIDTH-1:0]    out_pc,
    output logic [INSTR_WIDTH-1:0] out_instr,
    input  logic                   flush,
    output logic [CNT_WIDTH-1:0]   stall_cnt
);

    localparam int DW = PC_WIDTH + INSTR_WIDTH;

    skid_state_t          state_q;
    skid_state_t          state_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q;
    logic [CNT_WIDTH-1:0] stall_cnt_d;

    logic [DW-1:0] main_q;
    logic [DW-1:0] main_d;
    logic [DW-1:0] skid_q;
    logic [DW-1:0] skid_d;
    logic          main_wr_en;
    logic          skid_wr_en;
    logic          in_fire;
    logic          out_fire;

    assign in_ready  = (state_q != SKID);
    assign out_valid = (state_q != EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    assign out_pc    = main_q[DW-1 -: PC_WIDTH];
    assign out_instr = main_q[INSTR_WIDTH-1:0];

    // Next-state and register-load decode; flush overrides every transition.
    always_comb begin
        state_d    = state_q;
        main_wr_en = 1'b0;
        main_d     = {in_pc, in_instr};
        skid_wr_en = 1'b0;
        skid_d     = {in_pc, in_instr};
        if (flush) begin
            // Keep the PC for debug visibility, replace the instruction with a NOP.
            state_d    = EMPTY;
            main_wr_en = 1'b1;
            main_d     = {out_pc, INSTR_WIDTH'(INSTR_NOP)};
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d    = FULL;
                        main_wr_en = 1'b1;
                    end
                end
                FULL: begin
                    if (in_fire && out_fire) begin
                        main_wr_en = 1'b1;
                    end else if (in_fire) begin
                        state_d    = SKID;
                        skid_wr_en = 1'b1;
                    end else if (out_fire) begin
                        // Main data is left in place; out_valid alone retires it.
                        state_d = EMPTY;
                    end
                end
                SKID: begin
                    if (out_fire) begin
                        state_d    = FULL;
                        main_wr_en = 1'b1;
                        main_d     = skid_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // Saturating count of cycles where decode refuses a valid word.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && !flush && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // Occupancy state and debug counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= EMPTY;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

    dff_async_reset #(.WIDTH(DW)) u_main_reg (
        .clk   (clk),
        .rst   (rst),
        .wr_en (main_wr_en),
        .d     (main_d),
        .q     (main_q)
    );

    dff_async_reset #(.WIDTH(DW)) u_skid_reg (
        .clk   (clk),
        .rst   (rst),
        .wr_en (skid_wr_en),
        .d     (skid_d),
        .q     (skid_q)
    );

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Self-checking bench for if_id_skid_reg: queue-based occupancy model checked
// every cycle, plus literal expectations at the key points of each scenario.
module tb_if_id_skid_reg;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        flush;
    logic [15:0] stall_cnt;

    logic        in_ready4;
    logic        out_valid4;
    logic [31:0] out_pc4;
    logic [31:0] out_instr4;
    logic [3:0]  stall_cnt4;

    int errors = 0;
    int checks = 0;

    // Model: words held by the stage, oldest first; disp_* is what out_* shows.
    logic [63:0] mq[$];
    logic [31:0] disp_pc    = 32'h0;
    logic [31:0] disp_instr = 32'h0;
    int          cnt16      = 0;
    int          cnt4       = 0;

    if_id_skid_reg #(.PC_WIDTH(32), .INSTR_WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
        .flush(flush), .stall_cnt(stall_cnt)
    );

    if_id_skid_reg #(.PC_WIDTH(32), .INSTR_WIDTH(32), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .in_pc(in_pc), .in_instr(in_instr), .out_valid(out_valid4),
        .out_ready(out_ready), .out_pc(out_pc4), .out_instr(out_instr4),
        .flush(flush), .stall_cnt(stall_cnt4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return 32'h0010_0093 + (pc << 18);
    endfunction

    // Model update: reset clears everything; otherwise apply the handshake rules.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            disp_pc    = 32'h0;
            disp_instr = 32'h0;
            cnt16      = 0;
            cnt4       = 0;
        end else begin
            bit ofire;
            bit ifire;
            ofire = (mq.size() > 0) && out_ready;
            ifire = in_valid && (mq.size() < 2);
            if ((mq.size() > 0) && !out_ready && !flush) begin
                if (cnt16 < 65535) cnt16++;
                if (cnt4 < 15) cnt4++;
            end
            if (flush) begin
                mq.delete();
                disp_instr = 32'h0000_0013;
            end else begin
                if (ofire) void'(mq.pop_front());
                if (ifire) mq.push_back({in_pc, in_instr});
                if (mq.size() > 0) begin
                    disp_pc    = mq[0][63:32];
                    disp_instr = mq[0][31:0];
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("out_valid", {63'd0, out_valid}, {63'd0, mq.size() > 0});
        chk("in_ready", {63'd0, in_ready}, {63'd0, mq.size() < 2});
        chk("out_pc", {32'd0, out_pc}, {32'd0, disp_pc});
        chk("out_instr", {32'd0, out_instr}, {32'd0, disp_instr});
        chk("stall_cnt", {48'd0, stall_cnt}, 64'(cnt16));
        chk("stall_cnt4", {60'd0, stall_cnt4}, 64'(cnt4));
        chk("out_pc4", {32'd0, out_pc4}, {32'd0, disp_pc});
        chk("in_ready4", {63'd0, in_ready4}, {63'd0, mq.size() < 2});
        chk("out_valid4", {63'd0, out_valid4}, {63'd0, mq.size() > 0});
        chk("out_instr4", {32'd0, out_instr4}, {32'd0, disp_instr});
    end

    // One clock of stimulus: drive after the edge, return 1 time unit past the next edge.
    task automatic cyc(input bit iv, input logic [31:0] pc, input bit ordy, input bit fl);
        in_valid  = iv;
        in_pc     = pc;
        in_instr  = instr_of(pc);
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
        $display("cyc t=%0t in_v=%0b pc=0x%0h o_rdy=%0b flush=%0b -> out_v=%0b out_pc=0x%0h out_instr=0x%0h in_rdy=%0b stall=%0d",
                 $time, iv, pc, ordy, fl, out_valid, out_pc, out_instr, in_ready, stall_cnt);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_pc     = 32'h0;
        in_instr  = 32'h0010_0093;
        out_ready = 1'b1;
        flush     = 1'b0;
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_pc", {32'd0, out_pc}, 64'd0);
        chk("rst_out_instr", {32'd0, out_instr}, 64'd0);
        chk("rst_stall_cnt", {48'd0, stall_cnt}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        rst = 1'b1;

        // First accept right after reset release.
        cyc(1'b1, 32'h0, 1'b1, 1'b0);
        chk("first_out_valid", {63'd0, out_valid}, 64'd1);
        chk("first_out_instr", {32'd0, out_instr}, 64'h0010_0093);

        // Back-to-back streaming with decode always ready.
        for (int i = 1; i < 16; i++) begin
            cyc(1'b1, 32'(i * 4), 1'b1, 1'b0);
            chk("stream_pc", {32'd0, out_pc}, 64'(i * 4));
            chk("stream_in_ready", {63'd0, in_ready}, 64'd1);
        end
        chk("stream_stall", {48'd0, stall_cnt}, 64'd0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        chk("drain_out_valid", {63'd0, out_valid}, 64'd0);
        chk("drain_pc_held", {32'd0, out_pc}, 64'h3C);

        // Skid: main holds 0x10, decode stalls 4 cycles.
        cyc(1'b1, 32'h10, 1'b1, 1'b0);
        cyc(1'b1, 32'h14, 1'b0, 1'b0);
        chk("skid_in_ready", {63'd0, in_ready}, 64'd0);
        chk("skid_main_pc", {32'd0, out_pc}, 64'h10);
        repeat (3) cyc(1'b1, 32'h18, 1'b0, 1'b0);
        chk("skid_stall4", {48'd0, stall_cnt}, 64'd4);
        cyc(1'b1, 32'h18, 1'b1, 1'b0);
        chk("skid_order_14", {32'd0, out_pc}, 64'h14);
        cyc(1'b1, 32'h18, 1'b1, 1'b0);
        chk("skid_order_18", {32'd0, out_pc}, 64'h18);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        chk("skid_drained", {63'd0, out_valid}, 64'd0);

        // Flush while in SKID with a word offered.
        cyc(1'b1, 32'h20, 1'b0, 1'b0);
        cyc(1'b1, 32'h24, 1'b0, 1'b0);
        chk("pre_flush_in_ready", {63'd0, in_ready}, 64'd0);
        cyc(1'b1, 32'h40, 1'b0, 1'b1);
        chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_nop", {32'd0, out_instr}, 64'h13);
        chk("flush_pc_held", {32'd0, out_pc}, 64'h20);
        chk("flush_stall", {48'd0, stall_cnt}, 64'd5);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        chk("flush_no_40", {32'd0, out_pc}, 64'h20);

        // Saturation of the 4-bit counter.
        cyc(1'b1, 32'h44, 1'b0, 1'b0);
        repeat (20) cyc(1'b0, 32'h0, 1'b0, 1'b0);
        chk("sat_cnt4", {60'd0, stall_cnt4}, 64'hF);
        chk("sat_cnt16", {48'd0, stall_cnt}, 64'd25);

        // Asynchronous reset in SKID, asserted between edges.
        cyc(1'b1, 32'h50, 1'b0, 1'b0);
        chk("pre_arst_in_ready", {63'd0, in_ready}, 64'd0);
        #2 rst = 1'b0;
        #1;
        chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("arst_out_pc", {32'd0, out_pc}, 64'd0);
        chk("arst_stall", {48'd0, stall_cnt}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        cyc(1'b1, 32'h60, 1'b1, 1'b0);
        chk("post_arst_pc", {32'd0, out_pc}, 64'h60);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
